// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, SPI mode constants and edge helpers.
// Also used by the master side of the link.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } spi_state_t;

    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    function automatic logic rise_edge(input logic cur, input logic prev);
        return cur & ~prev;
    endfunction

    function automatic logic fall_edge(input logic cur, input logic prev);
        return ~cur & prev;
    endfunction

endpackage

// File: rtl/spi_if.sv
// SPI pins plus the parallel tx/rx handshake of the slave, bundled for port connection.
interface spi_if #(parameter int DATA_W = 8);
    logic              SCK;
    logic              SS_n;
    logic              MOSI;
    logic              MISO;
    logic              MISO_oe;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_overrun;
    logic              tx_underrun;

    modport slave (
        input  SCK, SS_n, MOSI, tx_data, tx_valid,
        output MISO, MISO_oe, tx_ready, rx_data, rx_valid, rx_overrun, tx_underrun
    );

    modport master (
        output SCK, SS_n, MOSI, tx_data, tx_valid,
        input  MISO, MISO_oe, tx_ready, rx_data, rx_valid, rx_overrun, tx_underrun
    );
endinterface

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input; resets to the line's idle level.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_r;

    // Shift chain, stage 0 takes the raw pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {STAGES{RST_VAL}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    assign q = sync_r[STAGES-1];
endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first, oversampled by clk_cpu. Frames are exchanged with
// the system through a tx_valid/tx_ready feed and an rx_valid strobe.
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic   clk_cpu,
    input  logic   rst_n,
    spi_if.slave   bus
);
    localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    logic sck_s, ss_s, mosi_s;
    logic sck_d_r, ss_d_r;
    logic sck_rise_s, sck_fall_s, ss_fall_s, ss_rise_s;
    logic [DATA_W-1:0] load_word_s;

    spi_state_t        state_r;
    logic [DATA_W-1:0] tx_shift_r;
    logic [DATA_W-1:0] rx_shift_r;
    logic [CNT_W-1:0]  bit_cnt_r;
    logic              done_r;
    logic              skip_fall_r;
    logic [DATA_W-1:0] rx_data_r;
    logic              rx_valid_r;
    logic              tx_ready_r;
    logic              oe_r;
    logic              underrun_r;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk(clk_cpu), .rst_n(rst_n), .d(bus.SCK),  .q(sck_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk(clk_cpu), .rst_n(rst_n), .d(bus.SS_n), .q(ss_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk_cpu), .rst_n(rst_n), .d(bus.MOSI), .q(mosi_s)
    );

    assign sck_rise_s  = rise_edge(sck_s, sck_d_r);
    assign sck_fall_s  = fall_edge(sck_s, sck_d_r);
    assign ss_fall_s   = fall_edge(ss_s, ss_d_r);
    assign ss_rise_s   = rise_edge(ss_s, ss_d_r);
    assign load_word_s = bus.tx_valid ? bus.tx_data : '0;

    // Frame FSM with shifters, handshake strobes and sticky status.
    always_ff @(posedge clk_cpu or negedge rst_n) begin
        if (!rst_n) begin
            sck_d_r     <= 1'b0;
            ss_d_r      <= 1'b1;
            state_r     <= ST_IDLE;
            tx_shift_r  <= '0;
            rx_shift_r  <= '0;
            bit_cnt_r   <= '0;
            done_r      <= 1'b0;
            skip_fall_r <= 1'b0;
            rx_data_r   <= '0;
            rx_valid_r  <= 1'b0;
            tx_ready_r  <= 1'b0;
            oe_r        <= 1'b0;
            underrun_r  <= 1'b0;
        end else begin
            sck_d_r    <= sck_s;
            ss_d_r     <= ss_s;
            rx_valid_r <= 1'b0;
            tx_ready_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    tx_shift_r  <= '0;
                    rx_shift_r  <= '0;
                    bit_cnt_r   <= '0;
                    done_r      <= 1'b0;
                    skip_fall_r <= 1'b0;
                    if (ss_fall_s) begin
                        state_r <= ST_LOAD;
                        oe_r    <= 1'b1;
                    end else begin
                        oe_r    <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    state_r    <= ST_SHIFT;
                    tx_shift_r <= load_word_s;
                    tx_ready_r <= bus.tx_valid;
                    underrun_r <= underrun_r | ~bus.tx_valid;
                end
                ST_SHIFT: begin
                    if (ss_rise_s) begin
                        state_r     <= ST_IDLE;
                        oe_r        <= 1'b0;
                        bit_cnt_r   <= '0;
                        done_r      <= 1'b0;
                        skip_fall_r <= 1'b0;
                    end else begin
                        if (sck_rise_s) begin
                            rx_shift_r <= {rx_shift_r[DATA_W-2:0], mosi_s};
                            bit_cnt_r  <= (bit_cnt_r == CNT_LAST) ? '0 : bit_cnt_r + CNT_W'(1);
                            done_r     <= (bit_cnt_r == CNT_LAST);
                        end else begin
                            done_r     <= 1'b0;
                        end
                        // The reload already presents the next MSB, so the
                        // following SCK fall must not shift it away.
                        if (done_r) begin
                            rx_data_r   <= rx_shift_r;
                            rx_valid_r  <= 1'b1;
                            tx_shift_r  <= load_word_s;
                            tx_ready_r  <= bus.tx_valid;
                            underrun_r  <= underrun_r | ~bus.tx_valid;
                            skip_fall_r <= 1'b1;
                        end else if (sck_fall_s) begin
                            if (skip_fall_r) begin
                                skip_fall_r <= 1'b0;
                            end else begin
                                tx_shift_r  <= {tx_shift_r[DATA_W-2:0], 1'b0};
                            end
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    oe_r    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.MISO        = tx_shift_r[DATA_W-1];
    assign bus.MISO_oe     = oe_r;
    assign bus.tx_ready    = tx_ready_r;
    assign bus.rx_data     = rx_data_r;
    assign bus.rx_valid    = rx_valid_r;
    assign bus.rx_overrun  = 1'b0;
    assign bus.tx_underrun = underrun_r;
endmodule

// File: tb/tb_spi_slave.sv
// Randomized bench for spi_slave: a bit-banged SPI master and tx producer drive two
// instances (2- and 3-stage synchronizers) and results are checked against a frame-level model.
module tb_spi_slave;
    logic clk_cpu = 1'b0;
    logic rst_n   = 1'b0;
    logic sck     = 1'b0;
    logic ss_n    = 1'b1;
    logic mosi    = 1'b0;

    always #5 clk_cpu = ~clk_cpu;

    logic [7:0] tx_mem [0:15];
    logic [3:0] wr_ptr = 4'd0;
    logic [3:0] rd_ptr = 4'd0;

    spi_if #(.DATA_W(8)) bus_a ();
    spi_if #(.DATA_W(8)) bus_b ();

    assign bus_a.SCK      = sck;
    assign bus_a.SS_n     = ss_n;
    assign bus_a.MOSI     = mosi;
    assign bus_a.tx_valid = (wr_ptr != rd_ptr);
    assign bus_a.tx_data  = tx_mem[rd_ptr];
    assign bus_b.SCK      = sck;
    assign bus_b.SS_n     = ss_n;
    assign bus_b.MOSI     = mosi;
    assign bus_b.tx_valid = 1'b0;
    assign bus_b.tx_data  = 8'h00;

    spi_slave #(.DATA_W(8), .SYNC_STAGES(2)) dut_a (.clk_cpu(clk_cpu), .rst_n(rst_n), .bus(bus_a));
    spi_slave #(.DATA_W(8), .SYNC_STAGES(3)) dut_b (.clk_cpu(clk_cpu), .rst_n(rst_n), .bus(bus_b));

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int txr_cnt = 0;
    logic [7:0] rx_a_q [$];
    logic [7:0] rx_b_q [$];
    int lat_a_q [$];
    int lat_b_q [$];
    logic       exp_underrun = 1'b0;
    logic [7:0] last_rx = 8'h00;
    logic [7:0] txb [4];
    logic [7:0] mob [4];

    always @(posedge clk_cpu) cyc <= cyc + 1;

    // Record rx strobes with their latency from the last SCK rise, and pop the tx feed.
    always @(posedge clk_cpu) begin
        #1;
        if (bus_a.rx_valid) begin
            rx_a_q.push_back(bus_a.rx_data);
            lat_a_q.push_back(cyc - rise_cyc);
        end
        if (bus_b.rx_valid) begin
            rx_b_q.push_back(bus_b.rx_data);
            lat_b_q.push_back(cyc - rise_cyc);
        end
        if (bus_a.tx_ready) begin
            rd_ptr  <= rd_ptr + 4'd1;
            txr_cnt <= txr_cnt + 1;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_cpu);
        #1;
    endtask

    task automatic check_rst_vals(input string p);
        check_eq({p, "_miso"},     32'(bus_a.MISO),        32'd0);
        check_eq({p, "_oe"},       32'(bus_a.MISO_oe),     32'd0);
        check_eq({p, "_rxdata"},   32'(bus_a.rx_data),     32'd0);
        check_eq({p, "_rxvalid"},  32'(bus_a.rx_valid),    32'd0);
        check_eq({p, "_txready"},  32'(bus_a.tx_ready),    32'd0);
        check_eq({p, "_overrun"},  32'(bus_a.rx_overrun),  32'd0);
        check_eq({p, "_underrun"}, 32'(bus_a.tx_underrun), 32'd0);
        check_eq({p, "_oe_b"},     32'(bus_b.MISO_oe),     32'd0);
    endtask

    task automatic clear_obs();
        wr_ptr = rd_ptr;
        rx_a_q.delete();
        rx_b_q.delete();
        lat_a_q.delete();
        lat_b_q.delete();
    endtask

    task automatic clock_bit(input logic b, input int half, inout logic miso_bits [$]);
        mosi = b;
        wait_cyc(half);
        miso_bits.push_back(bus_a.MISO);
        sck      = 1'b1;
        rise_cyc = cyc;
        wait_cyc(half);
        sck = 1'b0;
    endtask

    // One selection: ntx frames queued for the slave, nbits clocked from mob, then deselect.
    task automatic run_sel(input string tag, input logic [7:0] t [4], input int ntx,
                           input logic [7:0] m [4], input int nbits, input int half);
        logic miso_bits [$];
        int nf, opp, exp_rdy, base_rdy, k;
        logic [7:0] got_b, exp_b;
        clear_obs();
        for (int i = 0; i < ntx; i++) begin
            tx_mem[wr_ptr] = t[i];
            wr_ptr = wr_ptr + 4'd1;
        end
        wait_cyc(2);
        base_rdy = txr_cnt;
        ss_n = 1'b0;
        wait_cyc(8);
        for (int b = 0; b < nbits; b++) begin
            clock_bit(m[b / 8][7 - (b % 8)], half, miso_bits);
            if (b == 0) check_eq({tag, "_oe_on"}, 32'(bus_a.MISO_oe), 32'd1);
        end
        mosi = 1'b0;
        wait_cyc(8);
        ss_n = 1'b1;
        wait_cyc(8);

        nf      = nbits / 8;
        opp     = nf + 1;
        exp_rdy = (ntx < opp) ? ntx : opp;
        if (ntx < opp) exp_underrun = 1'b1;
        check_eq({tag, "_txready"},  32'(txr_cnt - base_rdy),  32'(exp_rdy));
        check_eq({tag, "_underrun"}, 32'(bus_a.tx_underrun),   32'(exp_underrun));
        check_eq({tag, "_oe_off"},   32'(bus_a.MISO_oe),       32'd0);
        for (int f = 0; f * 8 < nbits; f++) begin
            k     = (nbits - f * 8 >= 8) ? 8 : nbits - f * 8;
            got_b = 8'h00;
            for (int j = 0; j < k; j++) got_b = {got_b[6:0], miso_bits[f * 8 + j]};
            exp_b = (f < ntx) ? t[f] : 8'h00;
            exp_b = exp_b >> (8 - k);
            check_eq($sformatf("%s_miso_f%0d", tag, f), 32'(got_b), 32'(exp_b));
        end
        check_eq({tag, "_rxcnt_a"}, 32'(rx_a_q.size()), 32'(nf));
        check_eq({tag, "_rxcnt_b"}, 32'(rx_b_q.size()), 32'(nf));
        for (int f = 0; f < nf && f < rx_a_q.size(); f++) begin
            check_eq($sformatf("%s_rx_a%0d", tag, f),  32'(rx_a_q[f]),  32'(m[f]));
            check_eq($sformatf("%s_lat_a%0d", tag, f), 32'(lat_a_q[f]), 32'd4);
        end
        for (int f = 0; f < nf && f < rx_b_q.size(); f++) begin
            check_eq($sformatf("%s_rx_b%0d", tag, f),  32'(rx_b_q[f]),  32'(m[f]));
            check_eq($sformatf("%s_lat_b%0d", tag, f), 32'(lat_b_q[f]), 32'd5);
        end
        if (nf > 0) last_rx = m[nf - 1];
        check_eq({tag, "_rxhold"}, 32'(bus_a.rx_data), 32'(last_rx));
        clear_obs();
    endtask

    task automatic pulse_reset(input string tag);
        rst_n = 1'b0;
        #2;
        check_rst_vals(tag);
        sck  = 1'b0;
        ss_n = 1'b1;
        mosi = 1'b0;
        wait_cyc(3);
        rst_n = 1'b1;
        exp_underrun = 1'b0;
        last_rx      = 8'h00;
        wait_cyc(4);
    endtask

    initial begin
        logic miso_bits [$];
        int nf, ntx, nbits, half;

        wait_cyc(3);
        check_rst_vals("reset");
        rst_n = 1'b1;
        wait_cyc(4);

        txb = '{8'hA5, 8'h00, 8'h00, 8'h00};
        mob = '{8'h3C, 8'h00, 8'h00, 8'h00};
        run_sel("byte", txb, 1, mob, 8, 6);

        pulse_reset("rst1");
        txb = '{8'h00, 8'h00, 8'h00, 8'h00};
        mob = '{8'($urandom), 8'h00, 8'h00, 8'h00};
        run_sel("under", txb, 0, mob, 8, 5);

        txb = '{8'hFF, 8'h00, 8'h00, 8'h00};
        mob = '{8'h12, 8'h34, 8'h00, 8'h00};
        run_sel("b2b", txb, 2, mob, 16, 4);

        txb = '{8'($urandom), 8'h00, 8'h00, 8'h00};
        mob = '{8'($urandom), 8'h00, 8'h00, 8'h00};
        run_sel("abort", txb, 1, mob, 5, 4);
        txb = '{8'($urandom), 8'h00, 8'h00, 8'h00};
        mob = '{8'h81, 8'h00, 8'h00, 8'h00};
        run_sel("after_abort", txb, 1, mob, 8, 4);

        // Reset in the middle of a frame, then a clean frame.
        clear_obs();
        tx_mem[wr_ptr] = 8'h5A;
        wr_ptr = wr_ptr + 4'd1;
        ss_n = 1'b0;
        wait_cyc(8);
        for (int b = 0; b < 3; b++) clock_bit(1'b1, 5, miso_bits);
        wait_cyc(2);
        pulse_reset("rst_mid");
        check_eq("rst_mid_norx", 32'(rx_a_q.size() + rx_b_q.size()), 32'd0);
        clear_obs();
        txb = '{8'hC3, 8'h00, 8'h00, 8'h00};
        mob = '{8'h6E, 8'h00, 8'h00, 8'h00};
        run_sel("post_rst", txb, 1, mob, 8, 5);

        for (int it = 0; it < 20; it++) begin
            nf   = int'($urandom_range(1, 3));
            ntx  = int'($urandom_range(0, nf + 1));
            half = int'($urandom_range(4, 7));
            for (int i = 0; i < 4; i++) begin
                txb[i] = 8'($urandom);
                mob[i] = 8'($urandom);
            end
            nbits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, nf * 8 - 1)) : nf * 8;
            run_sel($sformatf("rnd%0d", it), txb, ntx, mob, nbits, half);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
